// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline control logic.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

   // X31 reads as zero and is never a real producer.
   localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Count enabled cycles, stick at the maximum value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: post-reset PC hold, data-memory freeze, branch flush,
// load-use and flag-hazard stalls, plus a saturating stall-cycle counter.
module pipeline_hazard_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_LAT  = 1,
   parameter int INIT_CYC = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid_d,
   input  logic [4:0]       rn_d,
   input  logic [4:0]       rm_d,
   input  logic             uses_rm_d,
   input  logic             cond_branch_d,
   input  logic             memread_e,
   input  logic [4:0]       rd_e,
   input  logic             flag_set_e,
   input  logic             branch_taken_e,
   input  logic             mem_req_m,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_bubble,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [3:0] INIT_LOAD = 4'(INIT_CYC - 1);
   localparam logic [3:0] LAT_LOAD  = 4'(MEM_LAT - 1);

   hz_state_t  state;
   logic [3:0] wait_cnt;
   logic       mem_done;
   logic       load_use;
   logic       flag_haz;
   logic       freeze_req;

   // The zero register never produces a value, so it cannot cause a load-use stall.
   assign load_use   = instr_valid_d && memread_e && (rd_e != XZR) &&
                       ((rd_e == rn_d) || (uses_rm_d && (rd_e == rm_d)));
   assign flag_haz   = instr_valid_d && cond_branch_d && flag_set_e;
   // mem_done blocks a second freeze for an access that has already been served.
   assign freeze_req = mem_req_m && !mem_done && (MEM_LAT != 0);

   // Pipeline-register controls decoded from the current state and hazards.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_bubble = 1'b0;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      case (state)
         INIT: begin
            pc_we       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end
         RUN: begin
            if (freeze_req) begin
               pc_we    = 1'b0;
               ifid_we  = 1'b0;
               idex_we  = 1'b0;
               exmem_we = 1'b0;
               memwb_we = 1'b0;
            end else if (branch_taken_e) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (load_use || flag_haz) begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_bubble = 1'b1;
            end
         end
         MEM_WAIT: begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
         end
         default: ;
      endcase
   end

   // Sequencer state: reset hold, run, and multi-cycle memory wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= INIT;
         wait_cnt <= INIT_LOAD;
         mem_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= RUN;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RUN: begin
               if (freeze_req) begin
                  if (MEM_LAT == 1) begin
                     mem_done <= 1'b1;
                  end else begin
                     state    <= MEM_WAIT;
                     wait_cnt <= LAT_LOAD;
                  end
               end else begin
                  // EX/MEM advanced, so the served access has left the M stage.
                  mem_done <= 1'b0;
               end
            end
            MEM_WAIT: begin
               if (wait_cnt == 4'd1) begin
                  state    <= RUN;
                  mem_done <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (reset),
      .en    ((state != INIT) && !pc_we),
      .clr   (1'b0),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two configurations driven in parallel,
// each checked every cycle against a behavioural model, plus literal expectations.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       instr_valid_d, uses_rm_d, cond_branch_d, memread_e;
   logic       flag_set_e, branch_taken_e, mem_req_m;
   logic [4:0] rn_d, rm_d, rd_e;

   logic        pc_we_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_bubble_a, exmem_we_a, memwb_we_a;
   logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_bubble_b, exmem_we_b, memwb_we_b;
   logic [3:0]  stall_a;
   logic [15:0] stall_b;
   logic [6:0]  outs_a, outs_b;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.MEM_LAT(3), .INIT_CYC(2), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .rn_d(rn_d), .rm_d(rm_d),
      .uses_rm_d(uses_rm_d), .cond_branch_d(cond_branch_d), .memread_e(memread_e), .rd_e(rd_e),
      .flag_set_e(flag_set_e), .branch_taken_e(branch_taken_e), .mem_req_m(mem_req_m),
      .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a), .idex_we(idex_we_a),
      .idex_bubble(idex_bubble_a), .exmem_we(exmem_we_a), .memwb_we(memwb_we_a),
      .stall_cycles(stall_a));

   pipeline_hazard_controller #(.MEM_LAT(1), .INIT_CYC(3), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .instr_valid_d(instr_valid_d), .rn_d(rn_d), .rm_d(rm_d),
      .uses_rm_d(uses_rm_d), .cond_branch_d(cond_branch_d), .memread_e(memread_e), .rd_e(rd_e),
      .flag_set_e(flag_set_e), .branch_taken_e(branch_taken_e), .mem_req_m(mem_req_m),
      .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b), .idex_we(idex_we_b),
      .idex_bubble(idex_bubble_b), .exmem_we(exmem_we_b), .memwb_we(memwb_we_b),
      .stall_cycles(stall_b));

   // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
   assign outs_a = {pc_we_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_bubble_a, exmem_we_a, memwb_we_a};
   assign outs_b = {pc_we_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_bubble_b, exmem_we_b, memwb_we_b};

   // Model state: cycles left in the post-reset hold, freeze cycles still owed
   // after the current one, whether the M-stage access was already served, stall count.
   typedef struct packed {
      logic [7:0]  init_left;
      logic [7:0]  freeze_left;
      logic        served;
      logic [31:0] cnt;
   } model_t;

   model_t ma = '{8'd2, 8'd0, 1'b0, 32'd0};
   model_t mb = '{8'd3, 8'd0, 1'b0, 32'd0};

   function automatic logic [6:0] exp_outs(input model_t m, input int lat);
      logic hz;
      logic [6:0] o;
      hz = instr_valid_d &&
           ((memread_e && (rd_e != 5'd31) && ((rd_e == rn_d) || (uses_rm_d && (rd_e == rm_d)))) ||
            (cond_branch_d && flag_set_e));
      o = 7'b1101011;
      if (m.init_left != 0)                                              o = 7'b0111111;
      else if ((m.freeze_left != 0) || (mem_req_m && !m.served && lat != 0)) o = 7'b0000000;
      else if (branch_taken_e)                                           o = 7'b1111111;
      else if (hz)                                                       o = 7'b0001111;
      return o;
   endfunction

   function automatic model_t next_model(input model_t m, input int lat, input logic [31:0] maxc);
      model_t n;
      logic [6:0] o;
      o = exp_outs(m, lat);
      n = m;
      if ((m.init_left == 0) && !o[6] && (m.cnt < maxc)) n.cnt = m.cnt + 32'd1;
      if (m.init_left != 0) begin
         n.init_left = m.init_left - 8'd1;
      end else if (m.freeze_left != 0) begin
         n.freeze_left = m.freeze_left - 8'd1;
         if (m.freeze_left == 8'd1) n.served = 1'b1;
      end else if (mem_req_m && !m.served && lat != 0) begin
         if (lat == 1) n.served = 1'b1;
         else          n.freeze_left = 8'(lat - 1);
      end else begin
         n.served = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ma <= '{8'd2, 8'd0, 1'b0, 32'd0};
         mb <= '{8'd3, 8'd0, 1'b0, 32'd0};
      end else begin
         ma <= next_model(ma, 3, 32'd15);
         mb <= next_model(mb, 1, 32'd65535);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks = checks + 2;
         if ((outs_a !== exp_outs(ma, 3)) || ({28'd0, stall_a} !== ma.cnt)) begin
            errors = errors + 1;
            $display("FAIL cycle_a t=%0t: outs=%b stall=%0d want outs=%b stall=%0d",
                     $time, outs_a, stall_a, exp_outs(ma, 3), ma.cnt);
         end
         if ((outs_b !== exp_outs(mb, 1)) || ({16'd0, stall_b} !== mb.cnt)) begin
            errors = errors + 1;
            $display("FAIL cycle_b t=%0t: outs=%b stall=%0d want outs=%b stall=%0d",
                     $time, outs_b, stall_b, exp_outs(mb, 1), mb.cnt);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      instr_valid_d = 1'b0; uses_rm_d = 1'b0; cond_branch_d = 1'b0; memread_e = 1'b0;
      flag_set_e = 1'b0; branch_taken_e = 1'b0; mem_req_m = 1'b0;
      rn_d = 5'd0; rm_d = 5'd0; rd_e = 5'd0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_in();
      repeat (2) tick();
      chk_en = 1'b1;
      reset = 1'b1;
      #2;
      chk("init1_pc_we", {31'd0, pc_we_a}, 32'd0);
      chk("init1_flush", {31'd0, ifid_flush_a}, 32'd1);
      chk("init1_stall", {28'd0, stall_a}, 32'd0);
      tick(); #2;
      chk("init2_outs", {25'd0, outs_a}, 32'h3F);
      tick(); #2;
      chk("run_pc_we", {31'd0, pc_we_a}, 32'd1);
      chk("run_flush", {31'd0, ifid_flush_a}, 32'd0);
      chk("run_stall", {28'd0, stall_a}, 32'd0);
      tick();
   endtask

   task automatic load_use(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                           input logic urm);
      instr_valid_d = 1'b1; memread_e = 1'b1; rd_e = rd; rn_d = rn; rm_d = rm; uses_rm_d = urm;
   endtask

   initial begin
      clear_in();
      do_reset();

      // LDUR X2 in EX, ADD X3,X2,X4 in ID: one stall cycle
      load_use(5'd2, 5'd2, 5'd4, 1'b1); #2;
      chk("lu_outs", {25'd0, outs_a}, 32'h0F);
      tick();
      clear_in(); instr_valid_d = 1'b1; rn_d = 5'd2; rm_d = 5'd4; uses_rm_d = 1'b1; #2;
      chk("lu_next_pc_we", {31'd0, pc_we_a}, 32'd1);
      chk("lu_next_bubble", {31'd0, idex_bubble_a}, 32'd0);
      tick();

      // X31 destination never stalls
      load_use(5'd31, 5'd31, 5'd31, 1'b1); #2;
      chk("xzr_pc_we", {31'd0, pc_we_a}, 32'd1);
      tick();
      // rm match only counts when rm is read
      load_use(5'd5, 5'd1, 5'd5, 1'b0); #2;
      chk("rm_unused_pc_we", {31'd0, pc_we_a}, 32'd1);
      tick();
      load_use(5'd5, 5'd1, 5'd5, 1'b1); #2;
      chk("rm_used_pc_we", {31'd0, pc_we_a}, 32'd0);
      tick();

      // flag hazard, and the same with no valid ID instruction
      clear_in(); instr_valid_d = 1'b1; cond_branch_d = 1'b1; flag_set_e = 1'b1; #2;
      chk("flag_outs", {25'd0, outs_a}, 32'h0F);
      tick();
      instr_valid_d = 1'b0; #2;
      chk("flag_novalid_pc_we", {31'd0, pc_we_a}, 32'd1);
      tick();

      // taken branch beats a simultaneous load-use
      clear_in(); load_use(5'd2, 5'd2, 5'd0, 1'b0); branch_taken_e = 1'b1; #2;
      chk("br_outs", {25'd0, outs_a}, 32'h7F);
      tick();
      clear_in();
      tick();

      // multi-cycle memory freeze on the MEM_LAT=3 instance
      do_reset();
      mem_req_m = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("freeze_outs", {25'd0, outs_a}, 32'd0);
         tick();
      end
      #2;
      chk("freeze_done_outs", {25'd0, outs_a}, 32'h6B);
      chk("freeze_stall", {28'd0, stall_a}, 32'd3);
      tick();
      mem_req_m = 1'b0;
      tick();

      // stall counter saturation
      do_reset();
      load_use(5'd7, 5'd7, 5'd0, 1'b0);
      repeat (20) tick();
      #2;
      chk("sat_stall_a", {28'd0, stall_a}, 32'd15);
      chk("sat_stall_b", {16'd0, stall_b}, 32'd20);
      tick();

      // reset in the middle of a memory wait
      do_reset();
      mem_req_m = 1'b1;
      tick();
      #2;
      chk("mw_frozen", {25'd0, outs_a}, 32'd0);
      reset = 1'b0;
      #1;
      chk("mw_reset_outs", {25'd0, outs_a}, 32'h3F);
      chk("mw_reset_stall", {28'd0, stall_a}, 32'd0);
      do_reset();
      tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
